alu_mdu: RTL and testbench

Parametrised, clocked ALU with an integrated iterative multiply/divide unit and architectural HI/LO registers. It is the successor to the single-cycle combinational ALU in the Mini-MIPS execute stage. Logic, arithmetic, compare and shift ops complete in one cycle. MULT/MULTU/DIV/DIVU run a WIDTH-step shift-add / restoring-divide sequence behind a start/busy/done handshake so the pipeline can stall on it.

---
 rtl/alu_mdu.sv | 146 ++++++++++++++
 tb/tb_alu_mdu.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/alu_mdu.sv
// rtl/alu_mdu.sv - clocked ALU with an iterative shift-add multiplier / restoring divider
// Single-cycle ops write out; MULT/MULTU/DIV/DIVU run WIDTH steps plus a sign-fix cycle into hi/lo.
module alu_mdu #(
   parameter  int WIDTH = 32,
   localparam int SW    = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [3:0]       alu_control,
   input  logic [1:0]       move_op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [SW-1:0]    shift,
   output logic [WIDTH-1:0] out,
   output logic             zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             busy,
   output logic             done
);
   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

   state_t               state_q;
   logic [SW-1:0]        cnt_q;
   logic [WIDTH-1:0]     out_q, hi_q, lo_q, a_q, dsr_q;
   logic [2*WIDTH-1:0]   acc_q;
   logic                 is_div_q, div0_q, neg_lo_q, neg_hi_q, done_q;

   logic                 a_neg, b_neg;
   logic [WIDTH-1:0]     a_mag, b_mag, alu_d, quo_fix, rem_fix;
   logic [WIDTH:0]       mul_sum, div_shift, div_diff;
   logic [2*WIDTH-1:0]   mul_d, div_d, prod_fix;

   // alu_control[0]==0 selects the signed MULT/DIV variant
   assign a_neg = ~alu_control[0] & a[WIDTH-1];
   assign b_neg = ~alu_control[0] & b[WIDTH-1];
   assign a_mag = a_neg ? -a : a;
   assign b_mag = b_neg ? -b : b;

   always_comb begin
      alu_d = out_q;
      case (alu_control)
         4'b0000: alu_d = a & b;
         4'b0001: alu_d = a | b;
         4'b0010: alu_d = a + b;
         4'b0011: alu_d = a ^ b;
         4'b0100: alu_d = ~(a | b);
         4'b0101: alu_d = a - b;
         4'b0110: alu_d = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
         4'b0111: alu_d = {{(WIDTH-1){1'b0}}, (a < b)};
         4'b1001: alu_d = b << shift;
         4'b1010: alu_d = b >> shift;
         4'b1011: alu_d = $signed(b) >>> shift;
         default: alu_d = out_q;
      endcase
   end

   // acc_q holds {partial product, multiplier} or {remainder, dividend/quotient}
   assign mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, dsr_q} : '0);
   assign mul_d     = {mul_sum, acc_q[WIDTH-1:1]};
   assign div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
   assign div_diff  = div_shift - {1'b0, dsr_q};
   assign div_d     = {(div_diff[WIDTH] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0]),
                       acc_q[WIDTH-2:0], ~div_diff[WIDTH]};

   assign prod_fix = neg_lo_q ? -acc_q : acc_q;
   assign quo_fix  = neg_lo_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
   assign rem_fix  = neg_hi_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         out_q    <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         a_q      <= '0;
         dsr_q    <= '0;
         acc_q    <= '0;
         is_div_q <= 1'b0;
         div0_q   <= 1'b0;
         neg_lo_q <= 1'b0;
         neg_hi_q <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  if (alu_control[3:2] == 2'b11) begin
                     state_q  <= alu_control[1] ? S_DIV : S_MUL;
                     is_div_q <= alu_control[1];
                     acc_q    <= {{WIDTH{1'b0}}, a_mag};
                     dsr_q    <= b_mag;
                     a_q      <= a;
                     div0_q   <= (b == '0);
                     neg_lo_q <= a_neg ^ b_neg;
                     neg_hi_q <= a_neg;
                     cnt_q    <= '0;
                  end else if (alu_control == 4'b1000) begin
                     case (move_op)
                        2'b00:   out_q <= lo_q;
                        2'b01:   out_q <= hi_q;
                        2'b10:   lo_q  <= a;
                        default: hi_q  <= a;
                     endcase
                     done_q <= 1'b1;
                  end else begin
                     out_q  <= alu_d;
                     done_q <= 1'b1;
                  end
               end
            end
            S_MUL, S_DIV: begin
               acc_q <= (state_q == S_DIV) ? div_d : mul_d;
               cnt_q <= cnt_q + SW'(1);
               if (cnt_q == SW'(WIDTH-1)) state_q <= S_FIX;
            end
            S_FIX: begin
               if (!is_div_q) begin
                  hi_q <= prod_fix[2*WIDTH-1:WIDTH];
                  lo_q <= prod_fix[WIDTH-1:0];
               end else if (div0_q) begin
                  hi_q <= a_q;
                  lo_q <= '1;
               end else begin
                  hi_q <= rem_fix;
                  lo_q <= quo_fix;
               end
               done_q  <= 1'b1;
               cnt_q   <= '0;
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign out  = out_q;
   assign zero = (out_q == '0);
   assign hi   = hi_q;
   assign lo   = lo_q;
   assign busy = (state_q != S_IDLE);
   assign done = done_q;
endmodule

// File: tb/tb_alu_mdu.sv
// tb/tb_alu_mdu.sv - directed self-checking bench for alu_mdu
module tb_alu_mdu;
   localparam int W = 32;

   logic          clk = 1'b0;
   logic          rst, start;
   logic [3:0]    alu_control;
   logic [1:0]    move_op;
   logic [W-1:0]  a, b;
   logic [4:0]    shift;
   logic [W-1:0]  out, hi, lo;
   logic          zero, busy, done;

   int checks = 0;
   int errors = 0;

   alu_mdu #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .start(start), .alu_control(alu_control),
      .move_op(move_op), .a(a), .b(b), .shift(shift),
      .out(out), .zero(zero), .hi(hi), .lo(lo), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic op1(input logic [3:0] ctl, input logic [1:0] mv,
                      input logic [W-1:0] av, input logic [W-1:0] bv, input logic [4:0] sh);
      alu_control = ctl; move_op = mv; a = av; b = bv; shift = sh; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   // issue a multi-cycle op, scramble the inputs, count cycles with busy high
   task automatic run_multi(input logic [3:0] ctl, input logic [W-1:0] av, input logic [W-1:0] bv,
                            output int cyc, output int early_done);
      op1(ctl, 2'b00, av, bv, 5'd0);
      a = ~av; b = bv + 32'd3; alu_control = 4'b0010;
      cyc = 0; early_done = 0;
      while (busy && cyc < 100) begin
         cyc++;
         if (done) early_done++;
         @(posedge clk); #1;
      end
   endtask

   task automatic multi_chk(input string tag, input logic [3:0] ctl, input logic [W-1:0] av,
                            input logic [W-1:0] bv, input logic [W-1:0] ehi, input logic [W-1:0] elo);
      int cyc, ed;
      logic [W-1:0] out_before;
      out_before = out;
      run_multi(ctl, av, bv, cyc, ed);
      check({tag, "_cycles"}, W'(cyc), W'(33));
      check({tag, "_done"}, W'(done), W'(1));
      check({tag, "_early_done"}, W'(ed), W'(0));
      check({tag, "_hi"}, hi, ehi);
      check({tag, "_lo"}, lo, elo);
      check({tag, "_out_held"}, out, out_before);
   endtask

   initial begin
      int d;
      rst = 1'b1; start = 1'b0; alu_control = '0; move_op = '0; a = '0; b = '0; shift = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_out", out, 32'h0);
      check("rst_zero", W'(zero), W'(1));
      check("rst_hi", hi, 32'h0);
      check("rst_lo", lo, 32'h0);
      check("rst_busy", W'(busy), W'(0));
      check("rst_done", W'(done), W'(0));
      rst = 1'b0;
      @(posedge clk); #1;

      op1(4'b0010, 2'b00, 32'hFFFF_FFFF, 32'h1, 5'd0);
      check("add_out", out, 32'h0);
      check("add_zero", W'(zero), W'(1));
      check("add_done", W'(done), W'(1));
      check("add_busy", W'(busy), W'(0));
      @(posedge clk); #1;
      check("add_done_drop", W'(done), W'(0));

      op1(4'b0110, 2'b00, 32'hFFFF_FFFF, 32'h1, 5'd0);
      check("slt_out", out, 32'h1);
      check("slt_zero", W'(zero), W'(0));
      op1(4'b0111, 2'b00, 32'hFFFF_FFFF, 32'h1, 5'd0);
      check("sltu_out", out, 32'h0);

      op1(4'b0000, 2'b00, 32'hF0F0_1234, 32'h0FF0_00FF, 5'd0);
      check("and_out", out, 32'h00F0_0034);
      op1(4'b0001, 2'b00, 32'hF0F0_1234, 32'h0FF0_00FF, 5'd0);
      check("or_out", out, 32'hFFF0_12FF);
      op1(4'b0011, 2'b00, 32'hF0F0_1234, 32'h0FF0_00FF, 5'd0);
      check("xor_out", out, 32'hFF00_12CB);
      op1(4'b0100, 2'b00, 32'hF0F0_1234, 32'h0FF0_00FF, 5'd0);
      check("nor_out", out, 32'h000F_ED00);
      op1(4'b0101, 2'b00, 32'hF0F0_1234, 32'h0FF0_00FF, 5'd0);
      check("sub_out", out, 32'hE100_1135);

      op1(4'b1011, 2'b00, 32'h0, 32'h8000_0000, 5'd4);
      check("sra_out", out, 32'hF800_0000);
      op1(4'b1010, 2'b00, 32'h0, 32'h8000_0000, 5'd4);
      check("srl_out", out, 32'h0800_0000);
      op1(4'b1001, 2'b00, 32'h0, 32'h3, 5'd31);
      check("sll_out", out, 32'h8000_0000);

      multi_chk("mult", 4'b1100, 32'hFFFF_FFFD, 32'h7, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
      op1(4'b1000, 2'b00, 32'h0, 32'h0, 5'd0);
      check("mflo_after_done", out, 32'hFFFF_FFEB);

      multi_chk("multu", 4'b1101, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
      multi_chk("mult_nn", 4'b1100, 32'hFFFF_FFFC, 32'hFFFF_FFFB, 32'h0, 32'h14);
      multi_chk("div_neg", 4'b1110, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
      multi_chk("div_negb", 4'b1110, 32'h7, 32'hFFFF_FFFE, 32'h1, 32'hFFFF_FFFD);
      multi_chk("divu_zero", 4'b1111, 32'h7, 32'h0, 32'h7, 32'hFFFF_FFFF);
      multi_chk("div_zero", 4'b1110, 32'hFFFF_FFFB, 32'h0, 32'hFFFF_FFFB, 32'hFFFF_FFFF);
      multi_chk("div_ovf", 4'b1110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000);
      multi_chk("divu", 4'b1111, 32'd100, 32'd7, 32'd2, 32'd14);

      op1(4'b1000, 2'b11, 32'h1234, 32'h0, 5'd0);
      check("mthi_done", W'(done), W'(1));
      check("mthi_hi", hi, 32'h1234);
      op1(4'b1000, 2'b01, 32'h0, 32'h0, 5'd0);
      check("mfhi_out", out, 32'h1234);
      op1(4'b1000, 2'b10, 32'h55, 32'h0, 5'd0);
      check("mtlo_lo", lo, 32'h55);
      check("mtlo_out_held", out, 32'h1234);

      op1(4'b1111, 2'b00, 32'd100, 32'd3, 5'd0);
      check("abort_busy", W'(busy), W'(1));
      repeat (4) @(posedge clk);
      #1;
      op1(4'b0010, 2'b00, 32'h1, 32'h1, 5'd0);
      check("ignored_add_out", out, 32'h1234);
      check("ignored_add_busy", W'(busy), W'(1));
      check("ignored_add_done", W'(done), W'(0));
      repeat (4) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("abort_hi", hi, 32'h0);
      check("abort_lo", lo, 32'h0);
      check("abort_busy_low", W'(busy), W'(0));
      check("abort_done", W'(done), W'(0));
      check("abort_out", out, 32'h0);
      d = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         if (done) d++;
      end
      check("abort_no_done", W'(d), W'(0));
      check("abort_hi_later", hi, 32'h0);

      op1(4'b0010, 2'b00, 32'd2, 32'd3, 5'd0);
      check("post_abort_add", out, 32'd5);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
